frame_config_writer: RTL and testbench

//  Write-side master of the tile configuration frame interface. Accepts a word stream
//  (command word, data word) from the bitstream loader, holds FrameData stable, then

---
 rtl/frame_config_writer_if.sv | 11 +
 rtl/frame_config_writer.sv | 136 +++++++++++++
 tb/tb_frame_config_writer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_config_writer_if.sv
// Word stream from the bitstream loader into the frame config writer.
interface frame_config_writer_if #(
  parameter int FrameBitsPerRow = 32
);
  logic [FrameBitsPerRow-1:0] s_data;
  logic                       s_valid;
  logic                       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/frame_config_writer.sv
// Write-side master of the tile configuration frame buses. The module takes a
// command word and then a data word, holds FrameData for one setup cycle,
// pulses one FrameStrobe bit for one cycle, and then holds the data for one more cycle.
//
// state     | meaning
// ----------+----------------------------------------------------
// IDLE      | ready for a command word (WRITE / END / NOP)
// WAIT_DATA | valid WRITE latched, waiting for its data word
// SETUP     | FrameData settled, strobe still low
// STROBE    | single strobe bit high for one cycle
// HOLD      | strobe low, FrameData held for latch hold time
module frame_config_writer #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumColumns      = 16
) (
  input  logic                                  CLK,
  input  logic                                  resetn,
  frame_config_writer_if.slave                  stream,
  output logic [FrameBitsPerRow-1:0]            FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                  busy,
  output logic                                  config_done,
  output logic                                  cmd_error
);

  localparam int SW = NumColumns * MaxFramesPerCol;
  localparam int IW = $clog2(SW);
  localparam logic [7:0]    MAX_FRAME = 8'(MaxFramesPerCol);
  localparam logic [7:0]    MAX_COL   = 8'(NumColumns);
  localparam logic [SW-1:0] ONE_BIT   = SW'(1);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_END   = 4'h2;

  // The command fields reach up to bit 19.
  if (FrameBitsPerRow < 20) begin : g_width_check
    $error("frame_config_writer: FrameBitsPerRow must be at least 20");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    SETUP     = 3'd2,
    STROBE    = 3'd3,
    HOLD      = 3'd4
  } state_t;

  state_t                     state_q, state_nxt;
  logic                       ready_q, ready_nxt;
  logic [SW-1:0]              strobe_q, strobe_nxt;
  logic [FrameBitsPerRow-1:0] frame_data_q;
  logic [IW-1:0]              strobe_idx_q;
  logic                       done_q, err_q;

  logic       accept;
  logic [3:0] opcode;
  logic [7:0] frame_f, col_f;
  logic       in_range;

  assign accept   = stream.s_valid & ready_q;
  assign opcode   = stream.s_data[3:0];
  assign frame_f  = stream.s_data[11:4];
  assign col_f    = stream.s_data[19:12];
  assign in_range = (frame_f < MAX_FRAME) && (col_f < MAX_COL);

  // State register; reset aborts any write in flight.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_nxt;
  end

  // Next-state logic: the fixed five-cycle walk for every accepted WRITE.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:      if (accept && opcode == OP_WRITE && in_range) state_nxt = WAIT_DATA;
      WAIT_DATA: if (accept) state_nxt = SETUP;
      SETUP:     state_nxt = STROBE;
      STROBE:    state_nxt = HOLD;
      HOLD:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output decode from the upcoming state, so ready and the strobe come straight from flops.
  always_comb begin
    ready_nxt  = (state_nxt == IDLE) || (state_nxt == WAIT_DATA);
    strobe_nxt = (state_nxt == STROBE) ? (ONE_BIT << strobe_idx_q) : '0;
  end

  // Registered handshake and strobe; both drop asynchronously on reset.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      ready_q  <= 1'b0;
      strobe_q <= '0;
    end else begin
      ready_q  <= ready_nxt;
      strobe_q <= strobe_nxt;
    end
  end

  // Command decode: latch the strobe index and update the sticky status flags.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      strobe_idx_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else if (state_q == IDLE && accept) begin
      case (opcode)
        OP_WRITE: begin
          if (in_range) strobe_idx_q <= IW'(col_f) * IW'(MaxFramesPerCol) + IW'(frame_f);
          else          err_q <= 1'b1;
        end
        OP_END:  done_q <= 1'b1;
        OP_NOP:  ;
        default: err_q <= 1'b1;
      endcase
    end
  end

  // Frame data register; it only loads in WAIT_DATA, so it stays fixed from SETUP through HOLD.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn)                              frame_data_q <= '0;
    else if (state_q == WAIT_DATA && accept)  frame_data_q <= stream.s_data;
  end

  assign stream.s_ready = ready_q;
  assign FrameData      = frame_data_q;
  assign FrameStrobe    = strobe_q;
  assign busy           = (state_q != IDLE);
  assign config_done    = done_q;
  assign cmd_error      = err_q;

endmodule

// File: tb/tb_frame_config_writer.sv
// Directed bench for frame_config_writer with hand-computed expectations.
module tb_frame_config_writer;
  localparam int MF = 20;
  localparam int FB = 32;
  localparam int NC = 16;
  localparam int SW = NC * MF;

  logic          CLK = 1'b0;
  logic          resetn = 1'b0;
  logic [FB-1:0] FrameData;
  logic [SW-1:0] FrameStrobe;
  logic          busy, config_done, cmd_error;

  frame_config_writer_if #(.FrameBitsPerRow(FB)) stream ();

  frame_config_writer #(
    .MaxFramesPerCol(MF),
    .FrameBitsPerRow(FB),
    .NumColumns(NC)
  ) dut (
    .CLK(CLK),
    .resetn(resetn),
    .stream(stream),
    .FrameData(FrameData),
    .FrameStrobe(FrameStrobe),
    .busy(busy),
    .config_done(config_done),
    .cmd_error(cmd_error)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe monitor: records every pulse with its index, cycle and data.
  int            cyc = 0;
  int            pulse_idx[$];
  int            pulse_cyc[$];
  logic [FB-1:0] pulse_data[$];
  int            multi_hot = 0;
  int            setup_bad = 0;
  logic [FB-1:0] data_prev;

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (FrameStrobe != '0) begin
      int idx;
      idx = -1;
      for (int i = SW - 1; i >= 0; i--) if (FrameStrobe[i]) idx = i;
      if ($countones(FrameStrobe) != 1) multi_hot++;
      if (FrameData !== data_prev) setup_bad++;
      pulse_idx.push_back(idx);
      pulse_cyc.push_back(cyc);
      pulse_data.push_back(FrameData);
    end
    data_prev = FrameData;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Present one word and return 1 time unit after the edge that accepts it.
  task automatic send_word(input logic [FB-1:0] w);
    int guard;
    guard = 0;
    stream.s_data  = w;
    stream.s_valid = 1'b1;
    while (!stream.s_ready && guard < 20) begin
      step(1);
      guard++;
    end
    if (!stream.s_ready) chk("ready_timeout", 64'(stream.s_ready), 64'd1);
    step(1);
  endtask

  task automatic drop_valid();
    stream.s_valid = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step(2);
    resetn = 1'b1;
    step(1);
  endtask

  function automatic logic [FB-1:0] wr_cmd(input int col, input int frame);
    return FB'((col << 12) | (frame << 4) | 1);
  endfunction

  int            exp_idx[4]  = '{19, 319, 100, 21};
  logic [FB-1:0] exp_dat[4]  = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
  int            b2b_col[4]  = '{0, 15, 5, 1};
  int            b2b_frm[4]  = '{19, 19, 0, 1};

  initial begin
    int n0;
    stream.s_data  = 32'h0000_2031;
    stream.s_valid = 1'b1;

    // 1: reset with the stream active
    #12;
    chk("rst_ready", 64'(stream.s_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data", 64'(FrameData), 64'd0);
    chk("rst_strobe", 64'(FrameStrobe != '0), 64'd0);
    chk("rst_done", 64'(config_done), 64'd0);
    chk("rst_err", 64'(cmd_error), 64'd0);
    @(posedge CLK);
    #1;
    stream.s_valid = 1'b0;
    resetn = 1'b1;
    step(1);
    chk("rel_ready", 64'(stream.s_ready), 64'd1);
    chk("rel_busy", 64'(busy), 64'd0);

    // 2: single write, col 2 frame 3 -> bit 43
    send_word(32'h0000_2031);
    send_word(32'hDEAD_BEEF);
    drop_valid();
    chk("w_setup_data", 64'(FrameData), 64'hDEAD_BEEF);
    chk("w_setup_strobe", 64'(FrameStrobe != '0), 64'd0);
    chk("w_setup_ready", 64'(stream.s_ready), 64'd0);
    chk("w_setup_busy", 64'(busy), 64'd1);
    step(1);
    chk("w_strobe_bit43", 64'(FrameStrobe[43]), 64'd1);
    chk("w_strobe_onehot", 64'($countones(FrameStrobe)), 64'd1);
    chk("w_strobe_data", 64'(FrameData), 64'hDEAD_BEEF);
    step(1);
    chk("w_hold_strobe", 64'(FrameStrobe != '0), 64'd0);
    chk("w_hold_data", 64'(FrameData), 64'hDEAD_BEEF);
    step(1);
    chk("w_idle_busy", 64'(busy), 64'd0);
    chk("w_idle_ready", 64'(stream.s_ready), 64'd1);
    chk("w_idle_data", 64'(FrameData), 64'hDEAD_BEEF);

    // 3: frame index out of range, then a write to bit 0
    n0 = pulse_idx.size();
    send_word(wr_cmd(0, 20));
    drop_valid();
    chk("oor_err", 64'(cmd_error), 64'd1);
    chk("oor_busy", 64'(busy), 64'd0);
    step(3);
    chk("oor_no_pulse", 64'(pulse_idx.size()), 64'(n0));
    send_word(wr_cmd(0, 0));
    send_word(32'h0000_0001);
    drop_valid();
    step(1);
    chk("oor_next_bit0", 64'(FrameStrobe[0]), 64'd1);
    chk("oor_next_onehot", 64'($countones(FrameStrobe)), 64'd1);
    chk("oor_next_data", 64'(FrameData), 64'd1);
    chk("oor_err_sticky", 64'(cmd_error), 64'd1);
    step(2);

    // 4: four back-to-back writes with s_valid held high
    n0 = pulse_idx.size();
    for (int k = 0; k < 4; k++) begin
      send_word(wr_cmd(b2b_col[k], b2b_frm[k]));
      send_word(exp_dat[k]);
    end
    drop_valid();
    step(8);
    chk("b2b_count", 64'(pulse_idx.size() - n0), 64'd4);
    if (pulse_idx.size() == n0 + 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("b2b_idx%0d", k), 64'(pulse_idx[n0+k]), 64'(exp_idx[k]));
        chk($sformatf("b2b_data%0d", k), 64'(pulse_data[n0+k]), 64'(exp_dat[k]));
        if (k > 0)
          chk($sformatf("b2b_gap%0d", k), 64'(pulse_cyc[n0+k] - pulse_cyc[n0+k-1]), 64'd5);
      end
    end

    // 5: NOP has no effect, END sets config_done without going busy
    send_word(32'h0000_0000);
    drop_valid();
    chk("nop_done", 64'(config_done), 64'd0);
    chk("nop_busy", 64'(busy), 64'd0);
    chk("nop_ready", 64'(stream.s_ready), 64'd1);
    send_word(32'h0000_0002);
    drop_valid();
    chk("end_done", 64'(config_done), 64'd1);
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_err_kept", 64'(cmd_error), 64'd1);

    // 6: reset during STROBE, then fresh command parsing
    send_word(32'h0000_2031);
    send_word(32'h0000_0055);
    drop_valid();
    step(1);
    chk("r6_strobe_on", 64'(FrameStrobe[43]), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("r6_strobe_off", 64'(FrameStrobe != '0), 64'd0);
    chk("r6_data", 64'(FrameData), 64'd0);
    chk("r6_ready", 64'(stream.s_ready), 64'd0);
    chk("r6_busy", 64'(busy), 64'd0);
    chk("r6_done", 64'(config_done), 64'd0);
    chk("r6_err", 64'(cmd_error), 64'd0);
    @(posedge CLK);
    #1;
    resetn = 1'b1;
    step(1);
    chk("r6_rel_ready", 64'(stream.s_ready), 64'd1);
    send_word(wr_cmd(16, 0));
    drop_valid();
    chk("col_oor_err", 64'(cmd_error), 64'd1);
    chk("col_oor_busy", 64'(busy), 64'd0);
    send_word(wr_cmd(3, 7));
    send_word(32'h0000_A5A5);
    drop_valid();
    step(1);
    chk("r6_bit67", 64'(FrameStrobe[67]), 64'd1);
    chk("r6_bit67_onehot", 64'($countones(FrameStrobe)), 64'd1);
    step(2);

    // 7: unknown opcode flags an error
    do_reset();
    chk("op_pre_err", 64'(cmd_error), 64'd0);
    send_word(32'h0000_2037);
    drop_valid();
    chk("op_bad_err", 64'(cmd_error), 64'd1);
    chk("op_bad_busy", 64'(busy), 64'd0);
    step(2);

    chk("never_multi_hot", 64'(multi_hot), 64'd0);
    chk("data_stable_at_strobe", 64'(setup_bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
